// File: rtl/xadac_ar_arb.sv
// Two-requester AXI read-address arbiter with ID-tagged R response routing.
// Define XADAC_AR_ARB_RR_EN for round-robin grants; otherwise fixed priority.
module xadac_ar_arb #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 128,
    parameter int unsigned IdWidth        = 1,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IdWidth-1:0]   s0_ar_id,
    input  logic [AddrWidth-1:0] s0_ar_addr,
    input  logic                 s0_ar_valid,
    output logic                 s0_ar_ready,
    output logic [IdWidth-1:0]   s0_r_id,
    output logic [DataWidth-1:0] s0_r_data,
    output logic                 s0_r_valid,
    input  logic                 s0_r_ready,
    input  logic [IdWidth-1:0]   s1_ar_id,
    input  logic [AddrWidth-1:0] s1_ar_addr,
    input  logic                 s1_ar_valid,
    output logic                 s1_ar_ready,
    output logic [IdWidth-1:0]   s1_r_id,
    output logic [DataWidth-1:0] s1_r_data,
    output logic                 s1_r_valid,
    input  logic                 s1_r_ready,
    output logic [IdWidth:0]     m_ar_id,
    output logic [AddrWidth-1:0] m_ar_addr,
    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    input  logic [IdWidth:0]     m_r_id,
    input  logic [DataWidth-1:0] m_r_data,
    input  logic                 m_r_valid,
    output logic                 m_r_ready,
    output logic [3:0]           outstanding,
    output logic                 err
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state_q, state_d;
    logic [IdWidth:0]     ar_id_q, ar_id_d;
    logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 can_grant, gnt0, gnt1, ar_hs, r_hs, sel;

    // Grants are only offered from IDLE, never under reset, and never past the limit.
    assign can_grant = !rst && (state_q == IDLE) && (cnt_q < 4'(MaxOutstanding));

`ifdef XADAC_AR_ARB_RR_EN
    logic rr_q, rr_d;

    assign gnt0 = can_grant && s0_ar_valid && (!rr_q || !s1_ar_valid);
    assign gnt1 = can_grant && s1_ar_valid && (rr_q || !s0_ar_valid);

    always_comb begin
        rr_d = rr_q;
        if (gnt0) rr_d = 1'b1;
        else if (gnt1) rr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
`else
    assign gnt0 = can_grant && s0_ar_valid;
    assign gnt1 = can_grant && s1_ar_valid && !s0_ar_valid;
`endif

    assign ar_hs = gnt0 || gnt1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ar_hs) state_d = ISSUE;
            ISSUE:   if (m_ar_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ar_valid  = (state_q == ISSUE);
        s0_ar_ready = gnt0;
        s1_ar_ready = gnt1;
    end

    always_comb begin
        ar_id_d   = ar_id_q;
        ar_addr_d = ar_addr_q;
        if (gnt0) begin
            ar_id_d   = {1'b0, s0_ar_id};
            ar_addr_d = s0_ar_addr;
        end else if (gnt1) begin
            ar_id_d   = {1'b1, s1_ar_id};
            ar_addr_d = s1_ar_addr;
        end
    end

    // A response with nothing in flight is flagged and never wraps the count.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q || (r_hs && (cnt_q == 4'd0));
        if (ar_hs && !r_hs)
            cnt_d = cnt_q + 4'd1;
        else if (r_hs && !ar_hs && (cnt_q != 4'd0))
            cnt_d = cnt_q - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
        end else begin
            ar_id_q   <= ar_id_d;
            ar_addr_q <= ar_addr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign m_ar_id     = ar_id_q;
    assign m_ar_addr   = ar_addr_q;
    assign outstanding = cnt_q;
    assign err         = err_q;

    assign sel        = m_r_id[IdWidth];
    assign s0_r_valid = m_r_valid && !sel;
    assign s1_r_valid = m_r_valid && sel;
    assign m_r_ready  = sel ? s1_r_ready : s0_r_ready;
    assign r_hs       = m_r_valid && m_r_ready;
    assign s0_r_id    = m_r_id[IdWidth-1:0];
    assign s1_r_id    = m_r_id[IdWidth-1:0];
    assign s0_r_data  = m_r_data;
    assign s1_r_data  = m_r_data;

endmodule

// File: tb/tb_xadac_ar_arb.sv
// Directed bench for xadac_ar_arb; expectations follow XADAC_AR_ARB_RR_EN.
module tb_xadac_ar_arb;

`ifdef XADAC_AR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [0:0]   s0_ar_id, s1_ar_id;
    logic [31:0]  s0_ar_addr, s1_ar_addr;
    logic         s0_ar_valid, s0_ar_ready, s1_ar_valid, s1_ar_ready;
    logic [0:0]   s0_r_id, s1_r_id;
    logic [127:0] s0_r_data, s1_r_data;
    logic         s0_r_valid, s0_r_ready, s1_r_valid, s1_r_ready;
    logic [1:0]   m_ar_id;
    logic [31:0]  m_ar_addr;
    logic         m_ar_valid, m_ar_ready;
    logic [1:0]   m_r_id;
    logic [127:0] m_r_data;
    logic         m_r_valid, m_r_ready;
    logic [3:0]   outstanding;
    logic         err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    xadac_ar_arb dut (
        .clk(clk), .rst(rst),
        .s0_ar_id(s0_ar_id), .s0_ar_addr(s0_ar_addr),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready),
        .s0_r_id(s0_r_id), .s0_r_data(s0_r_data),
        .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
        .s1_ar_id(s1_ar_id), .s1_ar_addr(s1_ar_addr),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready),
        .s1_r_id(s1_r_id), .s1_r_data(s1_r_data),
        .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
        .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_id(m_r_id), .m_r_data(m_r_data),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .outstanding(outstanding), .err(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       g;
        rst = 1'b1;
        s0_ar_id = '0; s0_ar_addr = '0; s0_ar_valid = 1'b1;
        s1_ar_id = '0; s1_ar_addr = '0; s1_ar_valid = 1'b1;
        s0_r_ready = 1'b0; s1_r_ready = 1'b0;
        m_ar_ready = 1'b0; m_r_id = '0; m_r_data = '0; m_r_valid = 1'b0;
        tick();
        tick();
        chk("rst_s0_ready", s0_ar_ready, 1'b0);
        chk("rst_s1_ready", s1_ar_ready, 1'b0);
        chk("rst_out", outstanding, 4'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_mvalid", m_ar_valid, 1'b0);
        chk("rst_mid", m_ar_id, 2'b00);
        chk("rst_maddr", m_ar_addr, 32'h0);

        // single request from s0
        rst = 1'b0; s1_ar_valid = 1'b0;
        s0_ar_id = 1'b1; s0_ar_addr = 32'h1000; m_ar_ready = 1'b1;
        #1;
        chk("t1_s0_ready", s0_ar_ready, 1'b1);
        chk("t1_s1_ready", s1_ar_ready, 1'b0);
        tick();
        s0_ar_valid = 1'b0;
        chk("t1_mvalid", m_ar_valid, 1'b1);
        chk("t1_mid", m_ar_id, 2'b01);
        chk("t1_maddr", m_ar_addr, 32'h1000);
        chk("t1_out", outstanding, 4'd1);
        chk("t1_issue_ready", s0_ar_ready, 1'b0);
        tick();
        chk("t1_idle", m_ar_valid, 1'b0);
        m_r_valid = 1'b1; m_r_id = 2'b01; s0_r_ready = 1'b1;
        m_r_data = 128'hDEAD_BEEF_0123;
        #1;
        chk("t1_r_s0v", s0_r_valid, 1'b1);
        chk("t1_r_s1v", s1_r_valid, 1'b0);
        chk("t1_r_mready", m_r_ready, 1'b1);
        chk("t1_r_id", s0_r_id, 1'b1);
        chk("t1_r_data", s0_r_data, 128'hDEAD_BEEF_0123);
        tick();
        m_r_valid = 1'b0; s0_r_ready = 1'b0;
        chk("t1_r_out", outstanding, 4'd0);
        chk("t1_r_err", err, 1'b0);

        // both requesters continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s0_ar_valid = 1'b1; s0_ar_id = 1'b0; s0_ar_addr = 32'hA0;
        s1_ar_valid = 1'b1; s1_ar_id = 1'b1; s1_ar_addr = 32'hB0;
        m_ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            g = RR ? k[0] : 1'b0;
            #1;
            chk("t2_s0_ready", s0_ar_ready, !g);
            chk("t2_s1_ready", s1_ar_ready, g);
            tick();
            chk("t2_mid", m_ar_id, g ? 2'b11 : 2'b00);
            chk("t2_maddr", m_ar_addr, g ? 32'hB0 : 32'hA0);
            tick();
        end
        chk("t3_out_full", outstanding, 4'd4);
        #1;
        chk("t3_stall_s0", s0_ar_ready, 1'b0);
        chk("t3_stall_s1", s1_ar_ready, 1'b0);
        tick();
        chk("t3_stall_mvalid", m_ar_valid, 1'b0);
        chk("t3_stall_out", outstanding, 4'd4);
        m_r_valid = 1'b1; m_r_id = 2'b10; s1_r_ready = 1'b1;
        m_r_data = 128'h55;
        #1;
        chk("t3_r_s1v", s1_r_valid, 1'b1);
        chk("t3_r_s0v", s0_r_valid, 1'b0);
        chk("t3_r_mready", m_r_ready, 1'b1);
        chk("t3_r_id", s1_r_id, 1'b0);
        chk("t3_r_data", s1_r_data, 128'h55);
        chk("t3_r_noready", s0_ar_ready, 1'b0);
        tick();
        m_r_valid = 1'b0; s1_r_ready = 1'b0;
        chk("t3_out_dec", outstanding, 4'd3);
        #1;
        chk("t3_regrant", s0_ar_ready, 1'b1);
        tick();
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0;
        chk("t3_out_refill", outstanding, 4'd4);
        chk("t3_mvalid", m_ar_valid, 1'b1);
        tick();

        // manager back-pressure while holding a request
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s1_ar_valid = 1'b1; s1_ar_id = 1'b1; s1_ar_addr = 32'h2222;
        m_ar_ready = 1'b0;
        #1;
        chk("t4_s1_ready", s1_ar_ready, 1'b1);
        tick();
        s0_ar_valid = 1'b1; s0_ar_addr = 32'h3333;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_hold_mvalid", m_ar_valid, 1'b1);
            chk("t4_hold_mid", m_ar_id, 2'b11);
            chk("t4_hold_maddr", m_ar_addr, 32'h2222);
            chk("t4_hold_rdy", {s0_ar_ready, s1_ar_ready}, 2'b00);
            tick();
        end
        m_ar_ready = 1'b1;
        tick();
        s0_ar_valid = 1'b0; s1_ar_valid = 1'b0; m_ar_ready = 1'b0;
        chk("t4_done_mvalid", m_ar_valid, 1'b0);
        chk("t4_done_out", outstanding, 4'd1);

        // simultaneous AR and R handshakes, then stray R
        s0_ar_valid = 1'b1; s0_ar_id = 1'b0; s0_ar_addr = 32'h30;
        m_r_valid = 1'b1; m_r_id = 2'b11; s1_r_ready = 1'b1;
        #1;
        chk("t5_s0_ready", s0_ar_ready, 1'b1);
        chk("t5_mready", m_r_ready, 1'b1);
        tick();
        s0_ar_valid = 1'b0; m_r_valid = 1'b0; s1_r_ready = 1'b0;
        chk("t5_out_same", outstanding, 4'd1);
        chk("t5_mvalid", m_ar_valid, 1'b1);
        m_ar_ready = 1'b1;
        tick();
        m_ar_ready = 1'b0;
        m_r_valid = 1'b1; m_r_id = 2'b00; s0_r_ready = 1'b1;
        tick();
        chk("t5_out_zero", outstanding, 4'd0);
        chk("t5_err_clean", err, 1'b0);
        tick();
        m_r_valid = 1'b0; s0_r_ready = 1'b0;
        chk("t5_err_set", err, 1'b1);
        chk("t5_out_nowrap", outstanding, 4'd0);
        tick();
        chk("t5_err_sticky", err, 1'b1);

        // reset in ISSUE drops the request
        s1_ar_valid = 1'b1; s1_ar_id = 1'b0; s1_ar_addr = 32'h44;
        tick();
        s1_ar_valid = 1'b0;
        chk("t6_issue", m_ar_valid, 1'b1);
        chk("t6_out", outstanding, 4'd1);
        rst = 1'b1;
        tick();
        chk("t6_mvalid", m_ar_valid, 1'b0);
        chk("t6_out_rst", outstanding, 4'd0);
        chk("t6_err_rst", err, 1'b0);
        chk("t6_mid", m_ar_id, 2'b00);
        rst = 1'b0;
        s0_ar_valid = 1'b1;
        #1;
        chk("t6_idle_grant", s0_ar_ready, 1'b1);
        s0_ar_valid = 1'b0;
        m_r_valid = 1'b1; m_r_id = 2'b10; s1_r_ready = 1'b1;
        #1;
        chk("t6_stray_s1v", s1_r_valid, 1'b1);
        tick();
        m_r_valid = 1'b0; s1_r_ready = 1'b0;
        chk("t6_stray_err", err, 1'b1);
        chk("t6_stray_out", outstanding, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xadac_ar_arb.md
XADAC_AR_ARB -- requirements
Module: xadac_ar_arb

Interface
REQ-001 SHALL provide parameter AddrWidth, default 32, AR address width.
REQ-002 SHALL provide parameter DataWidth, default 128, R data width.
REQ-003 SHALL provide parameter IdWidth, default 1, requester-side ID width; manager-side ID is IdWidth+1.
REQ-004 SHALL provide parameter MaxOutstanding, default 4, total reads in flight (1..15).
REQ-005 SHALL provide ports; one clock; reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- sN_ar_id  in  IdWidth  requester N (N=0,1) read ID.
- sN_ar_addr  in  AddrWidth  requester N read address.
- sN_ar_valid / sN_ar_ready  in / out  1  requester N AR handshake.
- sN_r_id  out  IdWidth  routed response ID.
- sN_r_data  out  DataWidth  routed response data.
- sN_r_valid / sN_r_ready  out / in  1  requester N R handshake.
- m_ar_id  out  IdWidth+1  {requester index, sN_ar_id}.
- m_ar_addr  out  AddrWidth  granted address.
- m_ar_valid / m_ar_ready  out / in  1  manager AR handshake.
- m_r_id  in  IdWidth+1  response ID; MSB is the requester index.
- m_r_data  in  DataWidth  response data.
- m_r_valid / m_r_ready  in / out  1  manager R handshake.
- outstanding  out  4  reads issued, not yet answered.
- err  out  1  sticky response-without-request flag.

Function
REQ-006 SHALL run FSM IDLE -> ISSUE -> IDLE; all R beats are single-beat.
REQ-007 In IDLE with outstanding < MaxOutstanding and any sN_ar_valid, SHALL assert sN_ar_ready for the granted N only, in that same cycle.
REQ-008 On that handshake SHALL register {N, sN_ar_id} and sN_ar_addr, and SHALL enter ISSUE the next cycle.
REQ-009 In ISSUE SHALL hold m_ar_valid=1 with stable id/addr and keep both sN_ar_ready=0.
REQ-010 In ISSUE SHALL return to IDLE on m_ar_valid && m_ar_ready.
REQ-011 SHALL have one-cycle request-to-m_ar_valid latency and a maximum rate of one grant per two cycles.
REQ-012 In IDLE with outstanding == MaxOutstanding SHALL hold both sN_ar_ready=0.
REQ-013 SHALL increment outstanding on the requester-side AR handshake.
REQ-014 SHALL decrement outstanding on the m_r handshake.
REQ-015 On a simultaneous increment and decrement SHALL leave outstanding unchanged.
REQ-016 R routing SHALL be combinational: sel=m_r_id[IdWidth]; s<sel>_r_valid=m_r_valid; other sN_r_valid=0.
REQ-017 R routing SHALL also drive m_r_ready=s<sel>_r_ready and sN_r_id/sN_r_data=m_r_id[IdWidth-1:0]/m_r_data.
REQ-018 On an m_r handshake with outstanding==0 SHALL set err and hold outstanding at 0 (no wrap).

Reset
REQ-019 On rst SHALL set: FSM=IDLE, outstanding=0, err=0, m_ar_valid=0, m_ar_id=0, m_ar_addr=0, RR pointer=0.
REQ-020 While rst is high SHALL drive both sN_ar_ready=0.
REQ-021 Reset mid-ISSUE SHALL drop the held request without handshake; later stray R beats SHALL be routed per REQ-016/017 and set err per REQ-018.

Configuration
REQ-022 With XADAC_AR_ARB_RR_EN defined SHALL use round-robin: pointer names the preferred requester and moves to the other requester after each grant.
REQ-023 Without XADAC_AR_ARB_RR_EN SHALL use fixed priority, requester 0 over requester 1, with no pointer state.

Verification
REQ-024 Bench SHALL cover: s0 valid, id=1, addr=0x1000, m_ar_ready=1 -> s0_ar_ready in cycle 0; m_ar_valid, m_ar_id=2'b01, m_ar_addr=0x1000 in cycle 1; outstanding=1.
REQ-025 Bench SHALL cover: both requesters valid continuously, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> grants 0,0,0,0.
REQ-026 Bench SHALL cover: m_ar_ready=0 for 5 cycles in ISSUE -> m_ar_id/m_ar_addr stable, sN_ar_ready=0, after ready one handshake.
REQ-027 Bench SHALL cover: 4 reads issued, no R -> outstanding=4, further requests stall; one R beat with m_r_id=2'b10 -> s1_r_valid=1, outstanding=3, next grant allowed.
REQ-028 Bench SHALL cover: R handshake and AR handshake in the same cycle -> outstanding unchanged; R beat with outstanding=0 -> err=1 sticky until rst.
REQ-029 Bench SHALL cover: rst asserted in ISSUE -> next cycle m_ar_valid=0, outstanding=0, FSM IDLE.
